// File: rtl/kbd_port_ctrl.sv
// PS/2 keyboard receive port: synchronizes the raw PS/2 clock/data lines,
// decodes 11-bit frames (start, 8 data LSB first, odd parity, stop) and queues
// good scancodes in a small circular FIFO read through a 32-bit port word
// {22'b0, overflow, ready, scancode}.
module kbd_port_ctrl #(
   parameter int FIFO_AW = 3,
   parameter int TIMEOUT = 4000
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        rd,
   output logic [31:0] rdata,
   output logic        ready
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    TLAST    = TW'(TIMEOUT - 1);
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // synchronizer and edge detector
   logic [1:0] clk_sync;
   logic [1:0] data_sync;
   logic       clk_prev;
   logic       fall;
   logic       bit_in;

   // receiver
   rx_state_t  state, state_d;
   logic [2:0] bit_cnt, bit_cnt_d;
   logic [7:0] shift, shift_d;
   logic       parity_bit, parity_bit_d;
   logic [TW-1:0] timer, timer_d;
   logic       push;

   // fifo
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] rptr, wptr;
   logic [FIFO_AW:0]   count;
   logic               overflow;
   logic               empty, full, pop, wr, drop;
   logic [7:0]         head;

   // Two-flop synchronizers plus one extra stage of the clock line; reset to 1
   // so releasing reset never looks like a falling edge.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
      end
   end

   assign fall   = clk_prev & ~clk_sync[1];
   assign bit_in = data_sync[1];

   // Receiver state register with its bit counter, shifter, parity and timer.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shift      <= 8'd0;
         parity_bit <= 1'b0;
         timer      <= '0;
      end else begin
         state      <= state_d;
         bit_cnt    <= bit_cnt_d;
         shift      <= shift_d;
         parity_bit <= parity_bit_d;
         timer      <= timer_d;
      end
   end

   // Frame decoding: everything advances on a falling edge; a silent line in
   // mid-frame for TIMEOUT cycles abandons the frame.
   always_comb begin
      state_d      = state;
      bit_cnt_d    = bit_cnt;
      shift_d      = shift;
      parity_bit_d = parity_bit;
      push         = 1'b0;
      timer_d      = (state == IDLE || fall) ? '0 : timer + 1'b1;

      unique case (state)
         IDLE: begin
            if (fall && !bit_in) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_d   = {bit_in, shift[7:1]};
               bit_cnt_d = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (fall) begin
               parity_bit_d = bit_in;
               state_d      = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               push    = bit_in & (^shift ^ parity_bit);
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state != IDLE && !fall && timer == TLAST) begin
         state_d   = IDLE;
         bit_cnt_d = 3'd0;
      end
   end

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign pop   = rd & ~empty;
   assign wr    = push & (~full | pop);
   assign drop  = push & full & ~pop;

   // FIFO storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wptr] <= shift;
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rptr     <= '0;
         wptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         if (wr && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !wr) begin
            count <= count - 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (rd) begin
            overflow <= 1'b0;
         end
      end
   end

   assign head  = empty ? 8'h00 : mem[rptr];
   assign ready = ~empty;
   assign rdata = {22'd0, overflow, ready, head};

endmodule

// File: doc/kbd_port_ctrl.md
KBD_PORT_CTRL -- requirements
Module: kbd_port_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_AW, default 3, meaning log2 of the scancode FIFO depth (8 entries).
REQ-002 The block SHALL have parameter TIMEOUT, default 4000, meaning the idle clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 The block SHALL have port clrn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 The block SHALL have port ps2_data, input, 1 bit: raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 The block SHALL have port rd, input, 1 bit: single-cycle read strobe, asserted when the CPU loads from the keyboard port.
REQ-008 The block SHALL have port rdata, output, 32 bits: the port word {22'b0, overflow, ready, scancode[7:0]}.
REQ-009 The block SHALL have port ready, output, 1 bit: FIFO non-empty, equal to rdata[8].

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be a synchronized level of 1 in the previous cycle and 0 in the current cycle.
REQ-011 The receiver FSM SHALL have states IDLE, DATA, PARITY and STOP, and all state changes SHALL occur only on a detected falling edge or on timeout.
REQ-012 IDLE: on an edge with data=0 (start bit) go to DATA with bit count 0; on an edge with data=1 stay in IDLE.
REQ-013 DATA: each edge shifts data into the shift register LSB first; after the 8th bit go to PARITY.
REQ-014 PARITY: the sampled bit SHALL be latched, then go to STOP.
REQ-015 STOP: on the edge, the frame SHALL be valid only when the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity); the FSM SHALL return to IDLE whether the frame is valid or not.
REQ-016 A frame that fails the parity or stop check SHALL be dropped silently: no push and no overflow change.
REQ-017 In any non-IDLE state, TIMEOUT clk cycles with no falling edge SHALL force IDLE and discard the partial frame; the timeout counter SHALL reset on every edge and while in IDLE.
REQ-018 A valid frame SHALL be pushed in the same cycle as the STOP-state edge; ready SHALL be 1 on the following clk cycle, at most 4 clk cycles after the raw ps2_clk falling edge.
REQ-019 The FIFO SHALL be circular, with FIFO_AW-bit read and write pointers and a (FIFO_AW+1)-bit count; the pointers SHALL wrap from 2^FIFO_AW-1 to 0.
REQ-020 rdata[7:0] SHALL be combinationally the head entry when non-empty and 0 when empty; rdata[8] = (count != 0); rdata[9] = overflow; rdata[31:10] = 0.
REQ-021 rd with the FIFO non-empty SHALL pop one entry at that clk edge, so the CPU samples the pre-pop rdata in the same cycle.
REQ-022 rd with the FIFO empty SHALL leave the pointers and count unchanged.
REQ-023 A push when full and without a simultaneous pop SHALL be dropped and SHALL set overflow to 1.
REQ-024 A push and a pop in the same cycle SHALL both take effect, with count unchanged, including when the FIFO is full.
REQ-025 overflow SHALL be sticky and SHALL be cleared by any rd; if a dropped push and an rd coincide, overflow SHALL end at 1.

Reset
REQ-026 While clrn=0: FSM=IDLE, bit count=0, shift register=0, timeout counter=0, synchronizers=1, FIFO pointers and count=0, overflow=0, so rdata=0x00000000 and ready=0.
REQ-027 Assertion of clrn mid-frame SHALL discard the partial frame and all FIFO contents.
REQ-028 After release of clrn, the first start bit SHALL be recognized only from a falling edge seen after the synchronizers refill (no spurious edge from the reset value).

Verification
REQ-029 The bench SHALL cover: frame 0x1C with parity 0 and stop 1 -> rdata=0x0000011C within 4 clk; then rd for 1 cycle -> rdata=0x00000000.
REQ-030 The bench SHALL cover: frame 0x1C with parity 1 -> dropped, rdata stays 0x00000000, FSM back in IDLE.
REQ-031 The bench SHALL cover: 9 valid frames 0x01..0x09 with no rd -> rdata=0x00000301; 8 successive rd calls return 0x01..0x08 (overflow cleared after the first rd); then ready=0.
REQ-032 The bench SHALL cover: start bit plus 3 data bits, then ps2_clk held high for TIMEOUT+1 cycles, then full frame 0xF0 -> rdata=0x000001F0 only.
REQ-033 The bench SHALL cover: FIFO full with rd and a push in the same cycle -> count stays 8, no overflow, new byte at the tail.
REQ-034 The bench SHALL cover: clrn pulsed low after the 5th data bit with 2 entries queued -> rdata=0 immediately; next full frame 0x5A -> rdata=0x0000015A.
